// File: rtl/rr_grant_sched4_if.sv
// rr_grant_sched4_if
//   Bundle between the requesters and the round-robin scheduler.
//   Parameter HOLD_MAX sizes the hold-counter debug view; it must match the
//   HOLD_MAX of the rr_grant_sched4 instance connected to this interface.
//   Signals:
//     en           scheduler enable (requester side drives)
//     req[3:0]     level requests, one per requester
//     done         owner release pulse
//     gnt[3:0]     one-hot grant, zero when no grant is active
//     gnt_idx[1:0] encoded owner index
//     gnt_valid    a grant is active
//     dbg_grant    FSM state view: 1 while in GRANT
//     dbg_hold_cnt current hold counter value
//   Valid/ready convention: there is no back-pressure on this path. A grant is
//   offered while gnt_valid is high; the owner ends it with a one-cycle done
//   pulse or by dropping its req bit, and the scheduler drops gnt_valid after
//   that edge.
//   Modports: master = requester side, slave = scheduler side.
interface rr_grant_sched4_if #(
    parameter int HOLD_MAX = 8
);
    localparam int CW = $clog2(HOLD_MAX + 1);

    logic          en;
    logic [3:0]    req;
    logic          done;
    logic [3:0]    gnt;
    logic [1:0]    gnt_idx;
    logic          gnt_valid;
    logic          dbg_grant;
    logic [CW-1:0] dbg_hold_cnt;

    modport master (
        output en, req, done,
        input  gnt, gnt_idx, gnt_valid, dbg_grant, dbg_hold_cnt
    );

    modport slave (
        input  en, req, done,
        output gnt, gnt_idx, gnt_valid, dbg_grant, dbg_hold_cnt
    );
endinterface

// File: rtl/rr_grant_sched4.sv
// rr_grant_sched4
//   Round-robin scheduler sharing one 2-to-4 one-hot select path among four
//   requesters. A winner is picked in IDLE, holds the grant until released,
//   and then becomes lowest priority. A released grant always returns to IDLE
//   for at least one cycle, so gnt is zero for one cycle between owners.
//   All outputs are registered.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    rr_grant_sched4_if.slave (en, req, done in; gnt, gnt_idx,
//            gnt_valid, dbg_grant, dbg_hold_cnt out)
//   Parameter:
//     HOLD_MAX  maximum grant length in cycles when ARB_TIMEOUT_EN is defined
//   Configuration macro:
//     ARB_TIMEOUT_EN  when defined, a grant is released after HOLD_MAX cycles
//                     even without done; otherwise grants have no time limit.
module rr_grant_sched4 #(
    parameter int HOLD_MAX = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_grant_sched4_if.slave   bus
);
    localparam int CW = $clog2(HOLD_MAX + 1);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [1:0]    gnt_idx_q, gnt_idx_d;
    logic [3:0]    gnt_q, gnt_d;
    logic          valid_q, valid_d;
    logic [1:0]    last_q, last_d;
    logic [CW-1:0] hold_q, hold_d;

    logic [1:0]    pick;
    logic [1:0]    cand;
    logic          found;
    logic          timeout;
    logic          release_c;

    // Winner search: first set request starting just after the last owner.
    // The lowest offset wins, so the last owner (offset 4) is checked last.
    always_comb begin
        pick  = 2'd0;
        cand  = 2'd0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!found && bus.req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        timeout = 1'b0;
`ifdef ARB_TIMEOUT_EN
        // hold_q counts completed GRANT cycles, so this ends the grant after
        // exactly HOLD_MAX cycles.
        timeout = (hold_q == CW'(HOLD_MAX - 1));
`else
        timeout = 1'b0;
`endif
        release_c = bus.done || !bus.req[gnt_idx_q] || !bus.en || timeout;
    end

    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        gnt_d     = gnt_q;
        valid_d   = valid_q;
        last_d    = last_q;
        hold_d    = hold_q;
        case (state_q)
            IDLE: begin
                if (bus.en && (|bus.req)) begin
                    state_d   = GRANT;
                    gnt_idx_d = pick;
                    gnt_d     = 4'b0001 << pick;
                    valid_d   = 1'b1;
                    hold_d    = '0;
                end
            end
            GRANT: begin
                if (release_c) begin
                    // Going back to IDLE (never straight to a new owner)
                    // is what creates the one-cycle bubble.
                    state_d = IDLE;
                    last_d  = gnt_idx_q;
                    gnt_d   = 4'b0000;
                    valid_d = 1'b0;
                end else if (hold_q != CW'(HOLD_MAX)) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_idx_q <= 2'd0;
            gnt_q     <= 4'b0000;
            valid_q   <= 1'b0;
            last_q    <= 2'd3;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_q     <= gnt_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.gnt_idx      = gnt_idx_q;
    assign bus.gnt_valid    = valid_q;
    assign bus.dbg_grant    = (state_q == GRANT);
    assign bus.dbg_hold_cnt = hold_q;
endmodule

// File: tb/tb_rr_grant_sched4.sv
// tb_rr_grant_sched4
//   Bench for rr_grant_sched4: directed scenarios plus random traffic, all
//   checked against a cycle-level reference model of the scheduling rules.
module tb_rr_grant_sched4;
    localparam int HOLD_MAX = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    rr_grant_sched4_if #(.HOLD_MAX(HOLD_MAX)) bus ();

    rr_grant_sched4 #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: owner number, busy flag, last owner, cycles held
    bit m_busy;
    int m_own;
    int m_last;
    int m_hold;

    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0;
        m_own  = 0;
        m_last = 3;
        m_hold = 0;
    endtask

    task automatic model_step(input logic e, input logic [3:0] r, input logic d);
        bit rel;
        if (m_busy) begin
            rel = d || !r[m_own] || !e;
`ifdef ARB_TIMEOUT_EN
            if (m_hold == HOLD_MAX - 1) rel = 1;
`endif
            if (rel) begin
                m_busy = 0;
                m_last = m_own;
            end else if (m_hold < HOLD_MAX) begin
                m_hold++;
            end
        end else if (e && r != 4'b0000) begin
            for (int k = 1; k <= 4; k++) begin
                if (r[(m_last + k) % 4]) begin
                    m_own = (m_last + k) % 4;
                    break;
                end
            end
            m_busy = 1;
            m_hold = 0;
        end
    endtask

    task automatic compare();
        check("gnt", bus.gnt, m_busy ? (32'd1 << m_own) : 32'd0);
        check("gnt_valid", bus.gnt_valid, m_busy);
        check("dbg_grant", bus.dbg_grant, m_busy);
        check("onehot0", $onehot0(bus.gnt), 1);
        if (m_busy) check("gnt_idx", bus.gnt_idx, m_own);
    endtask

    // driver: apply inputs at the falling edge, step model at the rising
    // edge, compare at the next falling edge
    task automatic cycle(input logic e, input logic [3:0] r, input logic d);
        bus.en   = e;
        bus.req  = r;
        bus.done = d;
        @(posedge clk);
        model_step(e, r, d);
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        bus.en   = 1'b0;
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        rst_n    = 1'b0;
        #3;
        model_reset();
        check("rst_gnt", bus.gnt, 4'b0000);
        check("rst_idx", bus.gnt_idx, 2'd0);
        check("rst_valid", bus.gnt_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int held;
        logic [3:0] r;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        model_reset();
        @(negedge clk);

        // 1: full rotation with done every 3rd grant cycle
        do_reset();
        exp_q = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        held  = 0;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
            if (m_busy) held++; else held = 0;
            if (m_busy && held == 1) check("t1_order", bus.gnt_idx, exp_q.pop_front());
            cycle(1'b1, 4'b1111, m_busy && held == 3);
        end
        check("t1_all_seen", exp_q.size(), 0);

        // 2: lone requester re-granted after one bubble
        do_reset();
        cycle(1'b1, 4'b0100, 1'b0);
        check("t2_first", bus.gnt, 4'b0100);
        cycle(1'b1, 4'b0100, 1'b1);
        check("t2_bubble", bus.gnt, 4'b0000);
        cycle(1'b1, 4'b0100, 1'b0);
        check("t2_again", bus.gnt, 4'b0100);

        // 3: owner 1 withdraws, 3 beats 0
        do_reset();
        cycle(1'b1, 4'b0010, 1'b0);
        check("t3_own1", bus.gnt, 4'b0010);
        cycle(1'b1, 4'b1001, 1'b0);
        check("t3_bubble", bus.gnt, 4'b0000);
        cycle(1'b1, 4'b1001, 1'b0);
        check("t3_next", bus.gnt, 4'b1000);

        // 4: en low ends grant 2, rotation continues at 3,0
        do_reset();
        cycle(1'b1, 4'b0100, 1'b0);
        check("t4_own2", bus.gnt_idx, 2'd2);
        cycle(1'b0, 4'b0100, 1'b0);
        check("t4_off", bus.gnt, 4'b0000);
        cycle(1'b0, 4'b0101, 1'b0);
        check("t4_idle_off", bus.gnt_valid, 1'b0);
        cycle(1'b1, 4'b0101, 1'b0);
        check("t4_next", bus.gnt_idx, 2'd0);

        // 5: asynchronous reset mid-grant
        do_reset();
        cycle(1'b1, 4'b0001, 1'b0);
        check("t5_granted", bus.gnt_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_gnt", bus.gnt, 4'b0000);
        check("t5_async_valid", bus.gnt_valid, 1'b0);
        model_reset();
        bus.req = 4'b1110;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 4'b1110, 1'b0);
        check("t5_after", bus.gnt_idx, 2'd1);

        // 6: held requests without done
        do_reset();
`ifdef ARB_TIMEOUT_EN
        exp_q = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                  4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0001};
`else
        exp_q = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                  4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        while (exp_q.size() > 0) begin
            cycle(1'b1, 4'b0011, 1'b0);
            check("t6_seq", bus.gnt, exp_q.pop_front());
        end

        // random traffic: sticky requests, occasional en drop and done pulse
        do_reset();
        r = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            cycle($urandom_range(0, 9) != 0, r, $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
